// File: rtl/chunk_add_ctrl.sv
// chunk_add_ctrl: W-bit adder (W=N*K) built by time-multiplexing one N-bit ripple-carry adder, LSB slice first
// Ports: clk, rst_n (async active-low); in_valid/in_ready accept a, b, cin;
//        out_valid/out_ready hand off sum, cout; busy is high while slices are being added.
// Option: define CHUNK_ADD_OVF_EN to add output ovf (signed overflow of the W-bit result).
module chunk_rca #(
  parameter int N = 8
) (
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
  input  logic         ci,
  output logic [N-1:0] s,
  output logic         co
);
  logic [N:0] c;
  assign c[0] = ci;
  for (genvar i = 0; i < N; i++) begin : g_fa
    assign s[i]   = a[i] ^ b[i] ^ c[i];
    assign c[i+1] = (a[i] & b[i]) | (c[i] & (a[i] ^ b[i]));
  end
  assign co = c[N];
endmodule

module chunk_add_ctrl #(
  parameter int N = 8,
  parameter int K = 4
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic [N*K-1:0] a,
  input  logic [N*K-1:0] b,
  input  logic           cin,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N*K-1:0] sum,
  output logic           cout,
  output logic           busy
`ifdef CHUNK_ADD_OVF_EN
  ,
  output logic           ovf
`endif
);
  localparam int W  = N * K;
  localparam int IW = K > 1 ? $clog2(K) : 1;
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic [W-1:0] a_r, b_r;
  logic [IW-1:0] idx;
  logic carry, acc, last, co;
  logic [N-1:0] s;
  assign in_ready  = state == IDLE || (state == DONE && out_ready);
  assign acc       = in_valid && in_ready;
  assign last      = idx == IW'(K - 1);
  assign out_valid = state == DONE;
  assign busy      = state == RUN;
  assign cout      = carry;
`ifdef CHUNK_ADD_OVF_EN
  // carry into the MSB is recovered from its operand and sum bits
  assign ovf = a_r[W-1] ^ b_r[W-1] ^ sum[W-1] ^ carry;
`endif
  chunk_rca #(.N(N)) u_rca (
    .a (a_r[idx*N +: N]),
    .b (b_r[idx*N +: N]),
    .ci(carry),
    .s (s),
    .co(co)
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  always_comb begin
    state_n = state;
    state_n = acc ? RUN :
              (state == RUN && last) ? DONE :
              (state == DONE && out_ready) ? IDLE : state;
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      a_r   <= '0;
      b_r   <= '0;
      idx   <= '0;
      carry <= 1'b0;
      sum   <= '0;
    end else if (acc) begin
      a_r   <= a;
      b_r   <= b;
      carry <= cin;
      idx   <= '0;
    end else if (state == RUN) begin
      sum[idx*N +: N] <= s;
      carry           <= co;
      idx             <= last ? idx : idx + IW'(1);
    end
endmodule

// File: tb/tb_chunk_add_ctrl.sv
// tb_chunk_add_ctrl: directed and randomized check of chunk_add_ctrl against a transaction-level adder model
module tb_chunk_add_ctrl;
  localparam int N = 8, K = 4, W = N * K;
  logic clk = 1'b0, rst_n = 1'b0, in_valid = 1'b0, out_ready = 1'b0, cin = 1'b0;
  logic [W-1:0] a = '0, b = '0;
  logic in_ready, out_valid, cout, busy;
  logic [W-1:0] sum;
`ifdef CHUNK_ADD_OVF_EN
  logic ovf;
`endif
  chunk_add_ctrl #(.N(N), .K(K)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .cin(cin), .out_valid(out_valid), .out_ready(out_ready),
    .sum(sum), .cout(cout), .busy(busy)
`ifdef CHUNK_ADD_OVF_EN
    , .ovf(ovf)
`endif
  );
  always #5 clk = ~clk;
  int errs = 0, checks = 0, nacc = 0, nhand = 0, age = 0;
  bit have_op = 0;
  logic [W+1:0] q[$];
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic logic [W+1:0] ref_add(input logic [W-1:0] x, input logic [W-1:0] y, input logic c);
    logic [W:0] r;
    logic v;
    r = {1'b0, x} + {1'b0, y} + {{W{1'b0}}, c};
    v = (x[W-1] == y[W-1]) && (r[W-1] != x[W-1]);
    return {v, r};
  endfunction
  task automatic cyc(input bit iv, input logic [W-1:0] av, input logic [W-1:0] bv, input bit cv, input bit ov);
    bit ev, ir, acc, hand;
    in_valid = iv; a = av; b = bv; cin = cv; out_ready = ov;
    #1;
    ev = have_op && age >= K;
    ir = !have_op || (ev && ov);
    chk("out_valid", out_valid, ev);
    chk("in_ready", in_ready, ir);
    chk("busy", busy, have_op && age < K);
    if (ev) begin
      chk("sum", sum, q[0][W-1:0]);
      chk("cout", cout, q[0][W]);
`ifdef CHUNK_ADD_OVF_EN
      chk("ovf", ovf, q[0][W+1]);
`endif
    end
    acc = iv && ir;
    hand = ev && ov;
    @(posedge clk);
    #1;
    if (hand) begin
      void'(q.pop_front());
      have_op = 0;
      nhand++;
    end
    if (acc) begin
      q.push_back(ref_add(av, bv, cv));
      have_op = 1;
      age = 0;
      nacc++;
    end else if (have_op && age < K) age++;
  endtask
  task automatic idle(input int n, input bit ov);
    for (int i = 0; i < n; i++) cyc(0, $urandom, $urandom, 1'($urandom_range(0, 1)), ov);
  endtask
  task automatic reset_vals(input string tag);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_sum"}, sum, 0);
    chk({tag, "_cout"}, cout, 0);
`ifdef CHUNK_ADD_OVF_EN
    chk({tag, "_ovf"}, ovf, 0);
`endif
  endtask
  initial begin
    int guard;
    #12;
    reset_vals("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1, 32'hFFFF_FFFF, 32'h0000_0001, 0, 1);
    idle(K + 1, 1);
    cyc(1, 32'h1234_5678, 32'h1111_1111, 1, 0);
    idle(K, 0);
    for (int i = 0; i < 5; i++) cyc(1, $urandom, $urandom, 0, 0);
    idle(1, 1);
    cyc(1, 32'hDEAD_BEEF, 32'h0BAD_F00D, 1, 1);
    idle(K, 1);
    cyc(1, 32'h8000_0000, 32'h8000_0000, 0, 1);
    idle(K, 1);
    chk("b2b_busy", busy, 0);
    cyc(1, 32'h7FFF_FFFF, 32'h0000_0001, 0, 1);
    idle(K + 1, 1);
    cyc(1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1);
    idle(K + 1, 1);
    cyc(1, 32'hAAAA_AAAA, 32'h5555_5555, 1, 1);
    idle(1, 1);
    rst_n = 1'b0;
    #1;
    reset_vals("midrst");
    q.delete();
    have_op = 0;
    nacc = 0;
    nhand = 0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle(K + 2, 1);
    cyc(1, 32'h0000_00FF, 32'h0000_0001, 0, 1);
    idle(K + 1, 1);
    guard = 0;
    while (nacc < 10000 && guard < 80000) begin
      cyc($urandom_range(0, 9) < 9, $urandom, $urandom, 1'($urandom_range(0, 1)), $urandom_range(0, 3) != 0);
      guard++;
    end
    chk("rand_done", nacc >= 10000, 1);
    guard = 0;
    while (q.size() > 0 && guard < 4 * K) begin
      idle(1, 1);
      guard++;
    end
    chk("drain_empty", q.size(), 0);
    chk("hand_count", nhand, nacc);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
